// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the capture-path FIFO write arbiter and its picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int hdr_flag_pos(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from last+1, or lowest index when RR=0.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter bit RR = 1'b1,
  localparam int IW = src_idx_w(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand_s;
  logic          hit_s;
  logic          found_s;

  // Scan candidates in priority order; the first valid one wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s        = RR ? IW'((int'(last_i) + 1 + k) % N) : IW'(k);
      hit_s         = valid_i[cand_s] & ~found_s;
      found_s       = found_s | hit_s;
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      idx_o         = hit_s ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Merges N record-oriented sources onto one FIFO write port, switching owner only
// at record boundaries and optionally tagging each record with a source header.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int W      = 8,
  parameter int N      = 3,
  parameter bit HDR_EN = 1'b1,
  parameter bit RR     = 1'b1
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           en_i,
  input  logic [N*W-1:0] src_data_i,
  input  logic [N-1:0]   src_valid_i,
  input  logic [N-1:0]   src_last_i,
  output logic [N-1:0]   src_ready_o,
  output logic [W-1:0]   wr_data_o,
  output logic           wr_en_o,
  input  logic           wr_ready_i,
  output logic [N-1:0]   grant_o,
  output logic           busy_o
);

  localparam int IW = src_idx_w(N);
  localparam int HB = hdr_flag_pos(W);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  pick_gnt_s;
  logic [IW-1:0] pick_idx_s;
  logic [W-1:0]  src_word_s [N];
  logic          xfer_s;

  for (genvar k = 0; k < N; k++) begin : g_word
    assign src_word_s[k] = src_data_i[k*W +: W];
  end

  rr_pick #(.N(N), .RR(RR)) u_pick (
    .valid_i (src_valid_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt_s),
    .idx_o   (pick_idx_s)
  );

  assign xfer_s  = wr_en_o & wr_ready_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

  // State register; last_q starts at N-1 so source 0 wins the first tie.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  // Next state: ownership changes only in IDLE, released on the last word.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i && (src_valid_i != '0)) begin
          grant_d = pick_gnt_s;
          gidx_d  = pick_idx_s;
          state_d = HDR_EN ? ST_HDR : ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (xfer_s && src_last_i[gidx_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: header word in HDR, granted source passed straight through in DATA.
  always_comb begin
    src_ready_o = '0;
    wr_en_o     = 1'b0;
    wr_data_o   = '0;
    case (state_q)
      ST_HDR: begin
        wr_en_o           = 1'b1;
        wr_data_o[HB]     = 1'b1;
        wr_data_o[IW-1:0] = gidx_q;
      end
      ST_DATA: begin
        wr_en_o             = src_valid_i[gidx_q];
        wr_data_o           = src_word_s[gidx_q];
        src_ready_o[gidx_q] = wr_ready_i;
      end
      default: begin
        wr_en_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench: config 0 is round-robin with headers, config 1 is
// strict priority without headers; both run concurrently against a record-level model.
module tb_fifo_wr_arbiter;

  localparam int W      = 8;
  localparam int N      = 3;
  localparam int RECS   = 20;
  localparam int DEPTH  = 128;
  localparam int GEN_C  = 700;
  localparam int MAX_C  = 5000;
  localparam int RST_AT = 250;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : cfg
    localparam bit RR_C  = (c == 0);
    localparam bit HDR_C = (c == 0);

    logic           rst_n, en, wr_ready, wr_en, busy;
    logic [N*W-1:0] sdata;
    logic [N-1:0]   svalid, slast, sready, grant;
    logic [W-1:0]   wdata;

    logic [W:0]     mem [N][DEPTH];
    int             head [N];
    int             tail [N];
    logic [W-1:0]   exp_q [$];
    logic [N-1:0]   cons;
    int             owner;
    int             lastp;
    bit             hdr_pend;
    bit             done;

    fifo_wr_arbiter #(.W(W), .N(N), .HDR_EN(HDR_C), .RR(RR_C)) dut (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .en_i        (en),
      .src_data_i  (sdata),
      .src_valid_i (svalid),
      .src_last_i  (slast),
      .src_ready_o (sready),
      .wr_data_o   (wdata),
      .wr_en_o     (wr_en),
      .wr_ready_i  (wr_ready),
      .grant_o     (grant),
      .busy_o      (busy)
    );

    task automatic chk_zero(input string tag);
      check($sformatf("cfg%0d %s grant", c, tag), int'(grant), 0);
      check($sformatf("cfg%0d %s busy", c, tag), int'(busy), 0);
      check($sformatf("cfg%0d %s ready", c, tag), int'(sready), 0);
      check($sformatf("cfg%0d %s wr_en", c, tag), int'(wr_en), 0);
      check($sformatf("cfg%0d %s wr_data", c, tag), int'(wdata), 0);
    endtask

    // Monitor: every accepted FIFO write must match the next expected word.
    always @(negedge clk) begin
      if (rst_n && wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cfg%0d unexpected_write: got 0x%0h, expected no write", c, wdata);
        end else begin
          check($sformatf("cfg%0d wr_data", c), int'(wdata), int'(exp_q.pop_front()));
        end
      end
    end

    // Sources, reference model and per-cycle output checks.
    initial begin
      int  rec_len, pick, s, left, cyc;
      bit  drained, rst_done;
      done = 1'b0; rst_n = 1'b0; en = 1'b0; wr_ready = 1'b0;
      svalid = '0; slast = '0; sdata = '0; cons = '0;
      owner = -1; hdr_pend = 1'b0; lastp = N - 1;
      drained = 1'b0; rst_done = 1'b0;
      for (int k = 0; k < N; k++) begin
        head[k] = 0;
        tail[k] = 0;
        for (int r = 0; r < RECS; r++) begin
          rec_len = $urandom_range(1, 4);
          for (int i = 0; i < rec_len; i++) begin
            mem[k][tail[k]] = {(i == rec_len - 1), W'($urandom)};
            tail[k]++;
          end
        end
      end

      repeat (2) @(posedge clk);
      #2;
      chk_zero("reset");
      rst_n = 1'b1;

      for (cyc = 0; cyc < MAX_C && !drained; cyc++) begin
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) if (cons[k]) head[k]++;
        if (cyc < GEN_C) begin
          en       = ($urandom_range(0, 9) != 0) && (cyc % 50 < 45);
          wr_ready = ($urandom_range(0, 3) != 0) && (cyc % 37 < 32);
        end else begin
          en       = 1'b1;
          wr_ready = ($urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < N; k++) begin
          svalid[k] = (head[k] < tail[k]) && ((cyc >= GEN_C) || ($urandom_range(0, 4) != 0));
          {slast[k], sdata[k*W +: W]} = (head[k] < tail[k]) ? mem[k][head[k]] : '0;
        end

        if (cyc >= RST_AT && !rst_done && owner >= 0 && !hdr_pend) begin
          rst_n = 1'b0;
          #1;
          chk_zero("async_reset");
          exp_q.delete();
          owner = -1; hdr_pend = 1'b0; lastp = N - 1; rst_done = 1'b1;
          #1 rst_n = 1'b1;
        end

        @(negedge clk);
        check($sformatf("cfg%0d grant", c), int'(grant), (owner < 0) ? 0 : (1 << owner));
        check($sformatf("cfg%0d busy", c), int'(busy), int'(owner >= 0));
        check($sformatf("cfg%0d wr_en", c), int'(wr_en),
              (owner < 0) ? 0 : (hdr_pend ? 1 : int'(svalid[owner])));
        check($sformatf("cfg%0d ready", c), int'(sready),
              (owner >= 0 && !hdr_pend && wr_ready) ? (1 << owner) : 0);
        cons = sready & svalid;

        if (owner < 0) begin
          if (en && (svalid != '0)) begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
              s = RR_C ? (lastp + 1 + i) % N : i;
              if (pick < 0 && svalid[s]) pick = s;
            end
            owner    = pick;
            hdr_pend = HDR_C;
            if (HDR_C) exp_q.push_back(W'((1 << (W - 1)) | pick));
            for (int i = head[pick]; i < tail[pick]; i++) begin
              exp_q.push_back(mem[pick][i][W-1:0]);
              if (mem[pick][i][W]) break;
            end
          end
        end else if (hdr_pend) begin
          if (wr_ready) hdr_pend = 1'b0;
        end else if (svalid[owner] && wr_ready && slast[owner]) begin
          lastp = owner;
          owner = -1;
        end

        left = 0;
        for (int k = 0; k < N; k++) left += tail[k] - head[k] - int'(cons[k]);
        if (cyc >= GEN_C && owner < 0 && left == 0) drained = 1'b1;
      end

      @(posedge clk);
      #2;
      check($sformatf("cfg%0d drained", c), int'(drained), 1);
      check($sformatf("cfg%0d reset_pulsed", c), int'(rst_done), 1);
      check($sformatf("cfg%0d words_left", c), exp_q.size(), 0);
      check($sformatf("cfg%0d final_busy", c), int'(busy), 0);
      done = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(cfg[0].done && cfg[1].done) && waited < MAX_C + 200) begin
      @(posedge clk);
      waited++;
    end
    if (!(cfg[0].done && cfg[1].done)) begin
      total++;
      bad++;
      $display("FAIL timeout: configs not done after %0d cycles", waited);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
